// File: rtl/nios2_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Imported by the channel and the top-level slave.
package nios2_multi_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_e;

  localparam int CTRL_ITO          = 0;
  localparam int CTRL_CONT         = 1;
  localparam int CTRL_START        = 2;
  localparam int CTRL_STOP         = 3;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

endpackage

// File: rtl/nios2_timer_channel.sv
// One timer channel: prescaler, down-counter, STATUS/CONTROL/PERIOD/SNAP registers
// and the channel's 32-bit read value.
module nios2_timer_channel
  import nios2_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 999999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_we,
  input  reg_e        i_reg,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic             r_to;
  logic             r_run;
  logic             r_ito;
  logic             r_cont;
  logic [PRE_W-1:0] r_prescale;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_snap;

  logic w_tick;
  logic w_wr_status;
  logic w_wr_control;
  logic w_wr_period;
  logic w_wr_snap;
  logic w_start;
  logic w_stop;

  // Decode the register targeted by a write strobe.
  always_comb begin
    w_wr_status  = 1'b0;
    w_wr_control = 1'b0;
    w_wr_period  = 1'b0;
    w_wr_snap    = 1'b0;
    if (i_we) begin
      case (i_reg)
        REG_STATUS:  w_wr_status  = 1'b1;
        REG_CONTROL: w_wr_control = 1'b1;
        REG_PERIOD:  w_wr_period  = 1'b1;
        REG_SNAP:    w_wr_snap    = 1'b1;
        default:     w_wr_status  = 1'b0;
      endcase
    end else begin
      w_wr_status = 1'b0;
    end
  end

  assign w_start = w_wr_control & i_wdata[CTRL_START];
  assign w_stop  = w_wr_control & i_wdata[CTRL_STOP];
  assign w_tick  = r_run & (r_pre_cnt == {PRE_W{1'b0}});
  assign o_irq   = r_to & r_ito;

  // Channel state; later statements override earlier ones, so a timeout beats a TO
  // clear while START/STOP and PERIOD writes beat the timeout's RUN update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to       <= 1'b0;
      r_run      <= 1'b0;
      r_ito      <= 1'b0;
      r_cont     <= 1'b0;
      r_prescale <= {PRE_W{1'b0}};
      r_pre_cnt  <= {PRE_W{1'b0}};
      r_period   <= RST_PER;
      r_cnt      <= RST_PER;
      r_snap     <= {CNT_W{1'b0}};
    end else begin
      if (w_start || w_wr_period) begin
        r_pre_cnt <= {PRE_W{1'b0}};
      end else if (w_tick) begin
        r_pre_cnt <= r_prescale;
      end else if (r_run) begin
        r_pre_cnt <= r_pre_cnt - PRE_ONE;
      end

      if (w_wr_status) begin
        r_to <= 1'b0;
      end

      if (w_tick) begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          r_cnt <= r_period;
          r_to  <= 1'b1;
          if (!r_cont) begin
            r_run <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt - CNT_ONE;
        end
      end

      if (w_wr_control) begin
        r_ito      <= i_wdata[CTRL_ITO];
        r_cont     <= i_wdata[CTRL_CONT];
        r_prescale <= i_wdata[CTRL_PRESCALE_LSB +: PRE_W];
        if (w_start) begin
          r_run <= 1'b1;
        end else if (w_stop) begin
          r_run <= 1'b0;
        end
      end

      if (w_wr_period) begin
        r_period <= i_wdata[CNT_W-1:0];
        r_cnt    <= i_wdata[CNT_W-1:0];
        r_run    <= 1'b0;
      end

      if (w_wr_snap) begin
        r_snap <= r_cnt;
      end
    end
  end

  // Read value of the addressed register; START/STOP strobes read back as 0.
  always_comb begin
    o_rdata = 32'd0;
    case (i_reg)
      REG_STATUS: begin
        o_rdata[STS_TO]  = r_to;
        o_rdata[STS_RUN] = r_run;
      end
      REG_CONTROL: begin
        o_rdata[CTRL_ITO]                      = r_ito;
        o_rdata[CTRL_CONT]                     = r_cont;
        o_rdata[CTRL_PRESCALE_LSB +: PRE_W]    = r_prescale;
      end
      REG_PERIOD: o_rdata = 32'(r_period);
      REG_SNAP:   o_rdata = 32'(r_snap);
      default:    o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/nios2_multi_timer.sv
// Multi-channel interval timer on a 32-bit Avalon-MM slave: channel decode,
// registered read mux and combined interrupt.
module nios2_multi_timer
  import nios2_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 999999
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+1:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] w_ch;
  reg_e            w_reg;
  logic [31:0]     w_rd [NUM_CH];
  logic [31:0]     w_rd_mux;

  if (NUM_CH > 1) begin : g_ch_sel
    assign w_ch = address[$clog2(NUM_CH)+1:2];
  end else begin : g_ch_one
    assign w_ch = 1'b0;
  end

  assign w_reg = reg_e'(address[1:0]);

  // Channel indices at or above NUM_CH match no instance, so they ignore
  // writes and read back as zero.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_we;
    assign w_we = chipselect & ~write_n & (w_ch == CH_W'(gi));

    nios2_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .i_we    (w_we),
      .i_reg   (w_reg),
      .i_wdata (writedata),
      .o_rdata (w_rd[gi]),
      .o_irq   (irq_vec[gi])
    );
  end

  // OR-combine the selected channel's read value.
  always_comb begin
    w_rd_mux = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rd_mux = w_rd_mux | ((w_ch == CH_W'(i)) ? w_rd[i] : 32'd0);
    end
  end

  // Read data is registered every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_nios2_multi_timer.sv
// Directed self-checking bench for nios2_multi_timer (five channels, so that
// channel index 5 is an unimplemented address).
module tb_nios2_multi_timer;

  localparam int NCH = 5;
  localparam int AW  = $clog2(NCH) + 2;

  logic           clk;
  logic           reset_n;
  logic [AW-1:0]  address;
  logic           chipselect;
  logic           write_n;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic           irq;
  logic [NCH-1:0] irq_vec;

  int n_checks;
  int n_pass;
  logic [31:0] rdv;

  nios2_multi_timer #(
    .NUM_CH       (NCH),
    .CNT_W        (32),
    .PRE_W        (8),
    .RESET_PERIOD (999999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered and left at a falling edge.
  task automatic bus_write(input int a, input logic [31:0] d);
    address    = AW'(a);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    address = AW'(a);
    @(negedge clk);
    d = readdata;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    clk        = 1'b0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    #1;
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_irq_vec", {27'd0, irq_vec}, 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;

    // Reset values and one-cycle read latency.
    bus_read(0, rdv);
    check_eq("ch0_status_rst", rdv, 32'd0);
    address = AW'(2);
    #1;
    check_eq("read_latency_old", readdata, 32'd0);
    @(negedge clk);
    check_eq("ch0_period_rst", readdata, 32'd999999);

    // ch1 continuous, period 4, prescale 0: timeout every 5 ticks.
    bus_write(6, 32'd4);
    bus_write(5, 32'h0000_0007);
    wait_cyc(4);
    check_eq("ch1_irq_before", {31'd0, irq_vec[1]}, 32'd0);
    wait_cyc(1);
    check_eq("ch1_irq_first", {31'd0, irq_vec[1]}, 32'd1);
    check_eq("ch1_irq_or", {31'd0, irq}, 32'd1);
    bus_write(4, 32'd0);
    check_eq("ch1_to_cleared", {31'd0, irq_vec[1]}, 32'd0);
    wait_cyc(3);
    check_eq("ch1_irq_gap", {31'd0, irq_vec[1]}, 32'd0);
    wait_cyc(1);
    check_eq("ch1_irq_second", {31'd0, irq_vec[1]}, 32'd1);
    bus_write(5, 32'h0000_0008);
    bus_write(4, 32'd0);
    bus_read(4, rdv);
    check_eq("ch1_status_stopped", rdv, 32'd0);
    check_eq("ch1_irq_quiet", {31'd0, irq}, 32'd0);

    // ch2 one-shot, period 2, prescale 3.
    bus_write(10, 32'd2);
    bus_write(9, 32'h0000_0305);
    wait_cyc(8);
    check_eq("ch2_irq_early", {31'd0, irq_vec[2]}, 32'd0);
    wait_cyc(4);
    check_eq("ch2_irq_set", {31'd0, irq_vec[2]}, 32'd1);
    bus_read(8, rdv);
    check_eq("ch2_status_oneshot", rdv, 32'd1);
    bus_write(11, 32'd0);
    bus_read(11, rdv);
    check_eq("ch2_cnt_reloaded", rdv, 32'd2);
    bus_read(9, rdv);
    check_eq("ch2_control_read", rdv, 32'h0000_0301);
    bus_write(9, 32'd0);
    bus_write(8, 32'd0);

    // ch0 snapshot, stop/hold, resume.
    bus_write(1, 32'h0000_0004);
    wait_cyc(3);
    bus_write(3, 32'd0);
    bus_write(1, 32'h0000_0008);
    bus_read(3, rdv);
    check_eq("ch0_snap_running", rdv, 32'd999996);
    bus_write(3, 32'd0);
    bus_read(3, rdv);
    check_eq("ch0_snap_held", rdv, 32'd999994);
    bus_read(0, rdv);
    check_eq("ch0_status_stopped", rdv, 32'd0);
    bus_read(1, rdv);
    check_eq("ch0_control_strobes", rdv, 32'd0);
    bus_write(1, 32'h0000_0004);
    wait_cyc(2);
    bus_write(3, 32'd0);
    bus_read(3, rdv);
    check_eq("ch0_snap_resumed", rdv, 32'd999992);
    bus_write(1, 32'h0000_0008);

    // ch3: TO clear coincides with a timeout; START|STOP keeps RUN.
    bus_write(14, 32'd4);
    bus_write(13, 32'h0000_0007);
    wait_cyc(9);
    bus_write(12, 32'd0);
    check_eq("ch3_set_wins", {31'd0, irq_vec[3]}, 32'd1);
    check_eq("ch3_irq_or", {31'd0, irq}, 32'd1);
    bus_write(13, 32'h0000_000C);
    bus_read(12, rdv);
    check_eq("ch3_start_wins", rdv, 32'd3);
    bus_write(13, 32'h0000_0009);
    bus_read(12, rdv);
    check_eq("ch3_stopped", rdv, 32'd1);

    // Unimplemented channel 5 ignores writes and reads zero.
    bus_write(22, 32'd7);
    bus_write(21, 32'h0000_0007);
    bus_read(22, rdv);
    check_eq("ch5_period_zero", rdv, 32'd0);
    bus_read(21, rdv);
    check_eq("ch5_control_zero", rdv, 32'd0);
    bus_read(6, rdv);
    check_eq("ch1_period_intact", rdv, 32'd4);
    bus_read(2, rdv);
    check_eq("ch0_period_intact", rdv, 32'd999999);

    // ch4: PERIOD write while running stops and reloads.
    bus_write(17, 32'h0000_0004);
    wait_cyc(2);
    bus_write(18, 32'd10);
    bus_read(16, rdv);
    check_eq("ch4_run_cleared", rdv, 32'd0);
    bus_write(19, 32'd0);
    bus_read(19, rdv);
    check_eq("ch4_cnt_new_period", rdv, 32'd10);
    bus_read(18, rdv);
    check_eq("ch4_period_read", rdv, 32'd10);

    // Asynchronous reset while ch3 holds an interrupt.
    check_eq("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_irq", {31'd0, irq}, 32'd0);
    check_eq("async_rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(14, rdv);
    check_eq("ch3_period_after_rst", rdv, 32'd999999);
    bus_read(12, rdv);
    check_eq("ch3_status_after_rst", rdv, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
